// File: rtl/hc_reduce_fp16.sv
// rtl/hc_reduce_fp16.sv - FP16 N-axis contraction y[b][h][p] = sum_n h[b][h][p][n]*C[b][n]

module fp16_mult_wrapper #(
    parameter int LAT = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        valid_out,
    output logic [15:0] result
);
    // Normal operands only: subnormals flush to zero, round to nearest even.
    function automatic logic [15:0] fmul(input logic [15:0] x, input logic [15:0] y);
        logic        s;
        logic [21:0] ox, oy, pm;
        logic [9:0]  m;
        logic [10:0] mr;
        logic        g, st;
        int          e;
        s = x[15] ^ y[15];
        if ((x[14:10] == 5'h1f && x[9:0] != 10'h0) || (y[14:10] == 5'h1f && y[9:0] != 10'h0))
            return 16'h7e00;
        if (x[14:10] == 5'h1f || y[14:10] == 5'h1f)
            return (x[14:10] == 5'h0 || y[14:10] == 5'h0) ? 16'h7e00 : {s, 15'h7c00};
        if (x[14:10] == 5'h0 || y[14:10] == 5'h0)
            return {s, 15'h0};
        ox = {11'h0, 1'b1, x[9:0]};
        oy = {11'h0, 1'b1, y[9:0]};
        pm = ox * oy;
        e  = int'(x[14:10]) + int'(y[14:10]) - 15;
        if (pm[21]) begin
            m = pm[20:11]; g = pm[10]; st = |pm[9:0]; e++;
        end else begin
            m = pm[19:10]; g = pm[9];  st = |pm[8:0];
        end
        mr = {1'b0, m} + {10'h0, g & (st | m[0])};
        if (mr[10]) begin m = 10'h0; e++; end
        else m = mr[9:0];
        if (e >= 31) return {s, 15'h7c00};
        if (e <= 0)  return {s, 15'h0};
        return {s, e[4:0], m};
    endfunction

    logic [15:0]    r_q [LAT];
    logic [LAT-1:0] v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < LAT; i++) r_q[i] <= '0;
        end else begin
            v_q[0] <= valid_in;
            r_q[0] <= fmul(a, b);
            for (int i = 1; i < LAT; i++) begin
                v_q[i] <= v_q[i-1];
                r_q[i] <= r_q[i-1];
            end
        end
    end

    assign valid_out = v_q[LAT-1];
    assign result    = r_q[LAT-1];
endmodule

module fp16_add_wrapper #(
    parameter int LAT = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        valid_out,
    output logic [15:0] result
);
    // Three extra bits (guard/round/sticky) below the 11-bit significand.
    function automatic logic [15:0] fadd(input logic [15:0] x_in, input logic [15:0] y_in);
        logic [15:0] x, y;
        logic [13:0] mx, my;
        logic [14:0] s;
        logic [9:0]  m;
        logic [10:0] mr;
        logic        st;
        int          e, d;
        x = x_in;
        y = y_in;
        if ((x[14:10] == 5'h1f && x[9:0] != 10'h0) || (y[14:10] == 5'h1f && y[9:0] != 10'h0))
            return 16'h7e00;
        if (x[14:10] == 5'h1f && y[14:10] == 5'h1f) return (x[15] != y[15]) ? 16'h7e00 : x;
        if (x[14:10] == 5'h1f) return x;
        if (y[14:10] == 5'h1f) return y;
        if (x[14:10] == 5'h0) return (y[14:10] == 5'h0) ? 16'h0 : y;
        if (y[14:10] == 5'h0) return x;
        if (y[14:0] > x[14:0]) begin x = y_in; y = x_in; end
        e  = int'(x[14:10]);
        d  = e - int'(y[14:10]);
        mx = {1'b1, x[9:0], 3'b0};
        my = {1'b1, y[9:0], 3'b0};
        st = 1'b0;
        for (int i = 0; i < 14; i++) if (i < d) st = st | my[i];
        my = (d > 13) ? 14'h0 : (my >> d);
        my[0] = my[0] | st;
        s = (x[15] == y[15]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
        if (s == 15'h0) return 16'h0;
        if (s[14]) begin s = {1'b0, s[14:1]} | {14'h0, s[0]}; e++; end
        for (int i = 0; i < 13; i++) if (!s[13]) begin s = s << 1; e--; end
        m  = s[12:3];
        mr = {1'b0, m} + {10'h0, s[2] & ((|s[1:0]) | m[0])};
        if (mr[10]) begin m = 10'h0; e++; end
        else m = mr[9:0];
        if (e >= 31) return {x[15], 15'h7c00};
        if (e <= 0)  return {x[15], 15'h0};
        return {x[15], e[4:0], m};
    endfunction

    logic [15:0]    r_q [LAT];
    logic [LAT-1:0] v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < LAT; i++) r_q[i] <= '0;
        end else begin
            v_q[0] <= valid_in;
            r_q[0] <= fadd(a, b);
            for (int i = 1; i < LAT; i++) begin
                v_q[i] <= v_q[i-1];
                r_q[i] <= r_q[i-1];
            end
        end
    end

    assign valid_out = v_q[LAT-1];
    assign result    = r_q[LAT-1];
endmodule

module hc_reduce_fp16 #(
    parameter int B     = 1,
    parameter int H     = 4,
    parameter int P     = 4,
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int M_LAT = 6,
    parameter int A_LAT = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [B*H*P*N*DW-1:0]   h_flat,
    input  logic [B*N*DW-1:0]       C_flat,
    output logic [B*H*P*DW-1:0]     y_flat,
    output logic                    busy,
    output logic                    done
);
    localparam int T   = B * H * P * N;
    localparam int O   = B * H * P;
    localparam int HPN = H * P * N;
    localparam int TW  = $clog2(T + 1);
    localparam int IW  = (T > 1) ? $clog2(T) : 1;
    localparam int OW  = $clog2(O + 1);
    localparam int KW  = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;
    state_t state_q, state_d;

    logic [TW-1:0] iss_q, cap_q;
    logic [IW-1:0] mul_idx_q;
    logic [IW-1:0] idx_pipe_q [M_LAT];
    logic          mul_v_q, mul_vo;
    logic [DW-1:0] mul_a_q, mul_b_q, mul_res;
    logic [DW-1:0] prod_q [T];
    logic [OW-1:0] out_q;
    logic [KW-1:0] k_q;
    logic          wait_q;
    logic          add_v_q, add_vo;
    logic [DW-1:0] add_a_q, add_b_q, add_res;
    logic [O*DW-1:0] y_q;

    logic          last_add, out_wr;
    logic [IW-1:0] base_idx, rd_idx;
    logic [DW-1:0] prod_base, prod_next;
    int            g_i, c_i, base_i, rd_i;

    always_comb begin
        g_i = int'(iss_q);
        if (g_i >= T) g_i = 0;
        c_i    = (g_i / HPN) * N + (g_i % N);
        base_i = int'(out_q) * N;
        if (base_i >= T) base_i = 0;
        // Second operand: prod[base+1] for the first add, prod[base+k+1] after k adds.
        rd_i = base_i + (wait_q ? int'(k_q) + 1 : 1);
        if (rd_i >= T) rd_i = 0;
        base_idx  = IW'(base_i);
        rd_idx    = IW'(rd_i);
        prod_base = prod_q[base_idx];
        prod_next = prod_q[rd_idx];
        last_add  = wait_q && add_vo && (k_q == KW'(N - 1));
        out_wr    = (state_q == S_ACC) && ((N == 1) || last_add);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_MUL;
            S_MUL:  if (mul_vo && cap_q == TW'(T - 1)) state_d = S_ACC;
            S_ACC:  if (out_wr && out_q == OW'(O - 1)) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_MUL) || (state_q == S_ACC);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_q     <= '0;
            cap_q     <= '0;
            mul_idx_q <= '0;
            mul_v_q   <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            out_q     <= '0;
            k_q       <= '0;
            wait_q    <= 1'b0;
            add_v_q   <= 1'b0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            y_q       <= '0;
            for (int i = 0; i < M_LAT; i++) idx_pipe_q[i] <= '0;
        end else begin
            mul_v_q <= 1'b0;
            add_v_q <= 1'b0;
            if (state_q == S_IDLE) begin
                iss_q  <= '0;
                cap_q  <= '0;
                out_q  <= '0;
                k_q    <= '0;
                wait_q <= 1'b0;
            end
            if (state_q == S_MUL && iss_q < TW'(T)) begin
                mul_v_q   <= 1'b1;
                mul_a_q   <= h_flat[g_i*DW +: DW];
                mul_b_q   <= C_flat[c_i*DW +: DW];
                mul_idx_q <= IW'(g_i);
                iss_q     <= iss_q + TW'(1);
            end
            idx_pipe_q[0] <= mul_idx_q;
            for (int i = 1; i < M_LAT; i++) idx_pipe_q[i] <= idx_pipe_q[i-1];
            if (mul_vo) cap_q <= cap_q + TW'(1);
            if (state_q == S_ACC) begin
                if (out_wr) begin
                    y_q[int'(out_q)*DW +: DW] <= (N == 1) ? prod_base : add_res;
                    out_q  <= out_q + OW'(1);
                    wait_q <= 1'b0;
                    k_q    <= '0;
                end else if (!wait_q) begin
                    add_v_q <= 1'b1;
                    add_a_q <= prod_base;
                    add_b_q <= prod_next;
                    k_q     <= KW'(1);
                    wait_q  <= 1'b1;
                end else if (add_vo) begin
                    add_v_q <= 1'b1;
                    add_a_q <= add_res;
                    add_b_q <= prod_next;
                    k_q     <= k_q + KW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mul_vo) prod_q[idx_pipe_q[M_LAT-1]] <= mul_res;
    end

    fp16_mult_wrapper #(.LAT(M_LAT)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (mul_v_q),
        .a         (mul_a_q),
        .b         (mul_b_q),
        .valid_out (mul_vo),
        .result    (mul_res)
    );

    fp16_add_wrapper #(.LAT(A_LAT)) u_add (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (add_v_q),
        .a         (add_a_q),
        .b         (add_b_q),
        .valid_out (add_vo),
        .result    (add_res)
    );

    assign y_flat = y_q;
endmodule

// File: tb/tb_hc_reduce_fp16.sv
// tb/tb_hc_reduce_fp16.sv - directed bench for hc_reduce_fp16 (default build plus an N=1 build)

module tb_hc_reduce_fp16;
    localparam int B = 1, H = 4, P = 4, N = 4, DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [B*H*P*N*DW-1:0] h_flat;
    logic [B*N*DW-1:0]     c_flat;
    logic [B*H*P*DW-1:0]   y_flat;
    logic                  busy, done;
    logic [B*H*P*DW-1:0]   h1_flat;
    logic [B*DW-1:0]       c1_flat;
    logic [B*H*P*DW-1:0]   y1_flat;
    logic                  busy1, done1;

    int n_asrt = 0;
    int n_fail = 0;
    int d_cyc, d_cnt, b_cnt, d1_cyc, a1_cnt;
    logic [15:0] c_ramp [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};

    always #5 clk = ~clk;

    hc_reduce_fp16 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .h_flat(h_flat), .C_flat(c_flat),
        .y_flat(y_flat), .busy(busy), .done(done)
    );

    hc_reduce_fp16 #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .h_flat(h1_flat), .C_flat(c1_flat),
        .y_flat(y1_flat), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle 1 is the first cycle after the edge that samples start.
    task automatic run(input int ncyc, input int extra_at, input int rst_at);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        d_cyc = -1; d_cnt = 0; b_cnt = 0; d1_cyc = -1; a1_cnt = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (done) begin d_cnt++; if (d_cyc < 0) d_cyc = c; end
            if (busy) b_cnt++;
            if (done1 && d1_cyc < 0) d1_cyc = c;
            if (dut1.add_v_q) a1_cnt++;
            start = (c == extra_at);
            if (c == rst_at)     rst_n = 1'b0;
            if (c == rst_at + 5) rst_n = 1'b1;
        end
    endtask

    initial begin
        for (int g = 0; g < 64; g++) h_flat[g*16 +: 16] = 16'h3C00;
        for (int n = 0; n < 4; n++)  c_flat[n*16 +: 16] = 16'h4000;
        for (int g = 0; g < 16; g++) h1_flat[g*16 +: 16] = 16'h4000;
        c1_flat = 16'h4200;

        repeat (3) @(negedge clk);
        check("rst_y_zero", {31'h0, |y_flat}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run(430, -1, -100);
        check("t1_done_cycle", d_cyc, 424);
        check("t1_done_count", d_cnt, 1);
        check("t1_busy_cycles", b_cnt, 423);
        for (int i = 0; i < 16; i++) check($sformatf("t1_y%0d", i), {16'h0, y_flat[i*16 +: 16]}, 32'h4800);
        check("n1_done_cycle", d1_cyc, 40);
        check("n1_adder_issues", a1_cnt, 0);
        for (int i = 0; i < 16; i++) check($sformatf("n1_y%0d", i), {16'h0, y1_flat[i*16 +: 16]}, 32'h4600);

        for (int n = 0; n < 4; n++) c_flat[n*16 +: 16] = c_ramp[n];
        run(424, 50, -100);
        check("t2_done_cycle", d_cyc, 424);
        check("t2_done_count", d_cnt, 1);
        check("t2_busy_cycles", b_cnt, 423);
        @(negedge clk);
        check("t2_done_low_425", {31'h0, done}, 32'h0);
        check("t2_busy_low_425", {31'h0, busy}, 32'h0);
        for (int i = 0; i < 16; i++) check($sformatf("t2_y%0d", i), {16'h0, y_flat[i*16 +: 16]}, 32'h4900);

        // Restart in cycle 425: done expected at absolute cycle 849.
        for (int g = 0; g < 64; g++) h_flat[g*16 +: 16] = ((g % 4) == ((g / 4) % 4)) ? 16'h3C00 : 16'h0000;
        run(424, -1, -100);
        check("t3_done_abs_cycle", 425 + d_cyc, 849);
        check("t3_done_count", d_cnt, 1);
        for (int i = 0; i < 16; i++) check($sformatf("t3_y%0d", i), {16'h0, y_flat[i*16 +: 16]}, {16'h0, c_ramp[i % 4]});
        @(negedge clk);

        for (int g = 0; g < 64; g++) h_flat[g*16 +: 16] = 16'h3C00;
        for (int n = 0; n < 4; n++)  c_flat[n*16 +: 16] = 16'h4000;
        run(450, -1, 200);
        check("t4_no_done", d_cnt, 0);
        check("t4_busy_cycles", b_cnt, 200);
        check("t4_busy_after", {31'h0, busy}, 32'h0);
        check("t4_y_zero", {31'h0, |y_flat}, 32'h0);

        run(430, -1, -100);
        check("t5_done_cycle", d_cyc, 424);
        check("t5_done_count", d_cnt, 1);
        for (int i = 0; i < 16; i++) check($sformatf("t5_y%0d", i), {16'h0, y_flat[i*16 +: 16]}, 32'h4800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
